// File: rtl/nonce_range_counter.sv
// Issues nonces from a loaded inclusive range [start, end] in steps of stride,
// using a valid/ready output stream; optionally restarts the range when it runs out.
module nonce_range_counter #(
    parameter int WIDTH    = 32,
    parameter int STRIDE_W = 8,
    parameter int WRAP     = 0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                ld,
    input  logic [WIDTH-1:0]    ld_start,
    input  logic [WIDTH-1:0]    ld_end,
    input  logic [STRIDE_W-1:0] ld_stride,
    input  logic                abort,
    input  logic                out_ready,
    output logic                out_valid,
    output logic [WIDTH-1:0]    out_nonce,
    output logic                out_last,
    output logic                busy,
    output logic                done,
    output logic                wrapped,
    output logic [1:0]          state_dbg
);

    // Handshake: a nonce is transferred on every rising edge where out_valid
    // and out_ready are both high; while out_valid && !out_ready the offered
    // out_nonce/out_last hold steady. out_valid never waits on out_ready.

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t              state_q;
    state_t              state_d;
    logic [WIDTH-1:0]    start_q;
    logic [WIDTH-1:0]    end_q;
    logic [STRIDE_W-1:0] stride_q;
    logic [WIDTH-1:0]    nonce_q;
    logic                wrapped_q;

    logic [WIDTH:0]      next_nonce;
    logic                last_c;
    logic                accept;

    // One extra bit keeps the carry so a sum past 2^WIDTH still counts as beyond end.
    assign next_nonce = {1'b0, nonce_q} + (WIDTH+1)'(stride_q);
    assign last_c     = (state_q == S_RUN) && (next_nonce > {1'b0, end_q});
    assign accept     = (state_q == S_RUN) && out_ready;

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            start_q   <= '0;
            end_q     <= '0;
            stride_q  <= '0;
            nonce_q   <= '0;
            wrapped_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            wrapped_q <= 1'b0;
            if (ld) begin
                start_q  <= ld_start;
                end_q    <= ld_end;
                stride_q <= (ld_stride == '0) ? STRIDE_W'(1) : ld_stride;
                nonce_q  <= ld_start;
            end else if (!abort && accept) begin
                if (!last_c) begin
                    nonce_q <= next_nonce[WIDTH-1:0];
                end else if (WRAP != 0) begin
                    nonce_q   <= start_q;
                    wrapped_q <= 1'b1;
                end
            end
        end
    end

    // Next-state logic; ld outranks abort, abort outranks an accept
    always_comb begin
        state_d = state_q;
        if (ld) begin
            state_d = (ld_start <= ld_end) ? S_RUN : S_DONE;
        end else if (abort) begin
            if (state_q != S_IDLE) begin
                state_d = S_IDLE;
            end
        end else if (accept && last_c && (WRAP == 0)) begin
            state_d = S_DONE;
        end
    end

    // Outputs
    always_comb begin
        out_valid = (state_q == S_RUN);
        busy      = (state_q == S_RUN);
        done      = (state_q == S_DONE);
        out_nonce = nonce_q;
        out_last  = last_c;
        wrapped   = wrapped_q;
        state_dbg = state_q;
    end

endmodule
